// File: rtl/mem_load_queue.sv
`default_nettype none
// ============================================================================
// Module   : mem_load_queue
// Brief    : MEM-stage in-order load/store completion queue between EX and WB;
//            matches in-order bus responses, aligns load data, retires in order.
// Revision : 1.0 - initial release
// ============================================================================
module mem_load_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   es2ms_valid,
    output logic                   ms_allowin,
    input  logic                   es_req_issued,
    input  logic [4:0]             es_ld_op,
    input  logic [1:0]             es_addr_lo,
    input  logic                   es_rf_we,
    input  logic [4:0]             es_rf_waddr,
    input  logic [PC_W-1:0]        es_result,
    input  logic [PC_W-1:0]        es_pc,
    input  logic                   data_sram_data_ok,
    input  logic [31:0]            data_sram_rdata,
    input  logic                   ws_allowin,
    output logic                   ms2ws_valid,
    output logic                   ms_rf_we,
    output logic [4:0]             ms_rf_waddr,
    output logic [PC_W-1:0]        ms_rf_wdata,
    output logic [PC_W-1:0]        ms_pc,
    output logic [31:0]            ms_busy_rf_mask,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] ms_count
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_DW = c_AW + 2;

    logic [DEPTH-1:0] valid_q, valid_d, owed_q, owed_d, done_q, done_d, rf_we_q, rf_we_d;
    logic [4:0]       ld_op_q   [DEPTH];
    logic [4:0]       ld_op_d   [DEPTH];
    logic [1:0]       addr_lo_q [DEPTH];
    logic [1:0]       addr_lo_d [DEPTH];
    logic [4:0]       waddr_q   [DEPTH];
    logic [4:0]       waddr_d   [DEPTH];
    logic [PC_W-1:0]  result_q  [DEPTH];
    logic [PC_W-1:0]  result_d  [DEPTH];
    logic [PC_W-1:0]  pc_q      [DEPTH];
    logic [PC_W-1:0]  pc_d      [DEPTH];
    logic [31:0]      rdata_q   [DEPTH];
    logic [31:0]      rdata_d   [DEPTH];
    logic [c_AW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [c_CW-1:0]  count_q, count_d;
    logic [c_DW-1:0]  discard_q, discard_d;

    logic             w_resp_found;
    logic [c_AW-1:0]  w_resp_ptr;
    logic [c_DW-1:0]  w_pend_cnt;
    logic             w_data_ok_live;
    logic             w_resp_match;
    logic             w_resp_dec;
    logic             w_head_ready;
    logic             w_enq;
    logic             w_deq;
    logic [31:0]      w_hd_rdata;
    logic [31:0]      w_sh;
    logic [PC_W-1:0]  w_ld_ext;

    // Responses arrive in order, so the owner is the oldest owed entry scanning from head.
    always_comb begin
        w_resp_found = 1'b0;
        w_resp_ptr   = head_q;
        w_pend_cnt   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_resp_found && valid_q[head_q + c_AW'(i)] && owed_q[head_q + c_AW'(i)]
                && !done_q[head_q + c_AW'(i)]) begin
                w_resp_found = 1'b1;
                w_resp_ptr   = head_q + c_AW'(i);
            end
            w_pend_cnt = w_pend_cnt + c_DW'(valid_q[i] & owed_q[i] & ~done_q[i]);
        end
    end

    always_comb begin
        w_data_ok_live = data_sram_data_ok && (discard_q == '0);
        w_resp_match   = w_data_ok_live && w_resp_found;
        w_resp_dec     = data_sram_data_ok && ((discard_q != '0) || w_resp_found);
        w_head_ready   = valid_q[head_q] &&
                         (done_q[head_q] || (w_resp_match && (w_resp_ptr == head_q)));
        ms_allowin     = (count_q != c_CW'(DEPTH)) && !flush;
        ms2ws_valid    = w_head_ready && !flush;
        w_enq          = es2ms_valid && ms_allowin;
        w_deq          = ms2ws_valid && ws_allowin;
    end

    always_comb begin
        valid_d   = valid_q;
        owed_d    = owed_q;
        done_d    = done_q;
        rf_we_d   = rf_we_q;
        ld_op_d   = ld_op_q;
        addr_lo_d = addr_lo_q;
        waddr_d   = waddr_q;
        result_d  = result_q;
        pc_d      = pc_q;
        rdata_d   = rdata_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        discard_d = discard_q;
        if (flush) begin
            // Every owed response becomes a discard, except one consumed this very cycle.
            valid_d   = '0;
            head_d    = tail_q;
            count_d   = '0;
            discard_d = discard_q + w_pend_cnt - c_DW'(w_resp_dec);
        end else begin
            if (w_resp_match) begin
                done_d[w_resp_ptr]  = 1'b1;
                rdata_d[w_resp_ptr] = data_sram_rdata;
            end else if (data_sram_data_ok && (discard_q != '0)) begin
                discard_d = discard_q - c_DW'(1);
            end
            if (w_deq) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + c_AW'(1);
            end
            if (w_enq) begin
                valid_d[tail_q]   = 1'b1;
                owed_d[tail_q]    = es_req_issued;
                done_d[tail_q]    = ~es_req_issued;
                rf_we_d[tail_q]   = es_rf_we;
                ld_op_d[tail_q]   = es_ld_op;
                addr_lo_d[tail_q] = es_addr_lo;
                waddr_d[tail_q]   = es_rf_waddr;
                result_d[tail_q]  = es_result;
                pc_d[tail_q]      = es_pc;
                rdata_d[tail_q]   = '0;
                tail_d            = tail_q + c_AW'(1);
            end
            count_d = count_q + c_CW'(w_enq) - c_CW'(w_deq);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q   <= '0;
            owed_q    <= '0;
            done_q    <= '0;
            rf_we_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            discard_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ld_op_q[i]   <= '0;
                addr_lo_q[i] <= '0;
                waddr_q[i]   <= '0;
                result_q[i]  <= '0;
                pc_q[i]      <= '0;
                rdata_q[i]   <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            owed_q    <= owed_d;
            done_q    <= done_d;
            rf_we_q   <= rf_we_d;
            ld_op_q   <= ld_op_d;
            addr_lo_q <= addr_lo_d;
            waddr_q   <= waddr_d;
            result_q  <= result_d;
            pc_q      <= pc_d;
            rdata_q   <= rdata_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            discard_q <= discard_d;
        end
    end

    // A head still waiting on the bus takes the live response data (zero-cycle bypass).
    always_comb begin
        w_hd_rdata = done_q[head_q] ? rdata_q[head_q] : data_sram_rdata;
        w_sh       = w_hd_rdata >> {addr_lo_q[head_q], 3'b000};
        case (ld_op_q[head_q])
            5'b10000: w_ld_ext = {{(PC_W-8){w_sh[7]}}, w_sh[7:0]};
            5'b01000: w_ld_ext = {{(PC_W-8){1'b0}}, w_sh[7:0]};
            5'b00100: w_ld_ext = {{(PC_W-16){w_sh[15]}}, w_sh[15:0]};
            5'b00010: w_ld_ext = {{(PC_W-16){1'b0}}, w_sh[15:0]};
            default:  w_ld_ext = PC_W'(w_sh);
        endcase
        ms_rf_we    = ms2ws_valid ? rf_we_q[head_q] : 1'b0;
        ms_rf_waddr = ms2ws_valid ? waddr_q[head_q] : 5'd0;
        ms_pc       = ms2ws_valid ? pc_q[head_q] : '0;
        ms_rf_wdata = ms2ws_valid ? ((|ld_op_q[head_q]) ? w_ld_ext : result_q[head_q]) : '0;
        ms_count    = count_q;
    end

    always_comb begin
        ms_busy_rf_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && rf_we_q[i] && (|ld_op_q[i]) && !done_q[i] && (waddr_q[i] != 5'd0))
                ms_busy_rf_mask[waddr_q[i]] = 1'b1;
        end
    end

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!resetn)
        !(data_sram_data_ok && (discard_q == '0) && !w_resp_found));
    a_discard_bound: assert property (@(posedge clk) disable iff (!resetn)
        discard_q <= c_DW'(2 * DEPTH));
    a_count_bound: assert property (@(posedge clk) disable iff (!resetn)
        count_q <= c_CW'(DEPTH));

endmodule
`default_nettype wire
